// File: rtl/task_arb_pkg.sv
// Shared types and helpers for the task frame arbiter: FSM state encoding,
// the one-hot grant helper and the default sizing.
package task_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_MAX = 16;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  // One-hot vector with bit idx set; an index outside width yields all zeros.
  function automatic logic [NUM_REQ_MAX-1:0] onehot(input int unsigned idx,
                                                    input int unsigned width);
    logic [NUM_REQ_MAX-1:0] v;
    v = '0;
    if ((idx < width) && (idx < NUM_REQ_MAX)) begin
      v[idx[3:0]] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/task_frame_arbiter_if.sv
// Bundle of buffer-side and core-side signals of the task frame arbiter.
//
// Handshake: i_req is a level held by buffer k while it owns a complete frame.
// The arbiter answers with a one-hot o_grant that doubles as the buffer's read
// enable; while granted, the buffer presents words qualified by i_enb[k]. There
// is no back-pressure: every word with i_enb high in a granted cycle is taken.
// The core ends the frame with a single-cycle i_output_last, which comes back
// as a single-cycle o_output_last[k] telling the buffer to reload.
interface task_frame_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  import task_arb_pkg::*;

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ-1:0]            i_enb;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic                          i_output_last;

  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_enb;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [NUM_REQ-1:0]            o_output_last;
  logic                          o_busy;
  logic [$clog2(NUM_REQ)-1:0]    o_active_id;
  logic                          o_timeout;
  arb_state_t                    o_dbg_state;

  modport slave (
    input  i_req, i_enb, i_data, i_output_last,
    output o_grant, o_enb, o_data, o_output_last, o_busy, o_active_id,
           o_timeout, o_dbg_state
  );

  modport master (
    output i_req, i_enb, i_data, i_output_last,
    input  o_grant, o_enb, o_data, o_output_last, o_busy, o_active_id,
           o_timeout, o_dbg_state
  );

endinterface

// File: rtl/task_frame_arbiter_picker.sv
// Rotating-priority encoder: first set request bit at or above i_ptr, wrapping.
module task_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    int j;
    o_valid = 1'b0;
    o_idx   = '0;
    j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % NUM_REQ;
      if (i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/task_frame_arbiter.sv
// Round-robin arbiter sharing one task core among NUM_REQ frame buffers.
// Holds the grant FSM, the rotation pointer, the watchdog timer, the data mux
// and all output registers.
module task_frame_arbiter
  import task_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  task_frame_arbiter_if.slave  bus
);

  localparam int AID_W = $clog2(NUM_REQ);
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_SAT    = '1;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [AID_W-1:0]       r_ptr;
  logic [AID_W-1:0]       w_ptr_nxt;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_nxt;
  logic [TW-1:0]          w_timer_inc;
  logic                   w_expire;
  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     w_grant_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic [AID_W-1:0]       r_active_id;
  logic [AID_W-1:0]       w_active_nxt;
  logic [NUM_REQ-1:0]     r_output_last;
  logic [NUM_REQ-1:0]     w_output_last_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic                   r_enb;
  logic [DATA_WIDTH-1:0]  r_data;

  logic                   w_pick_valid;
  logic [AID_W-1:0]       w_pick;
  logic [NUM_REQ_MAX-1:0] w_pick_onehot;
  logic [NUM_REQ_MAX-1:0] w_active_onehot;
  logic                   w_lane_enb;
  logic [DATA_WIDTH-1:0]  w_lane_data;

  task_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (AID_W)
  ) u_picker (
    .i_req   (bus.i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick)
  );

  assign w_pick_onehot   = onehot(int'(w_pick), NUM_REQ);
  assign w_active_onehot = onehot(int'(r_active_id), NUM_REQ);

  // Lane of the granted buffer; other buffers' strobes never reach the core.
  assign w_lane_enb  = bus.i_enb[r_active_id];
  assign w_lane_data = bus.i_data[int'(r_active_id)*DATA_WIDTH +: DATA_WIDTH];

  // The timer "reaches" the limit on the cycle whose increment lands on it, so
  // the abort pulse appears TIMEOUT_CYCLES cycles after the grant rises.
  assign w_timer_inc = (r_timer == T_SAT) ? r_timer : r_timer + TW'(1);
  assign w_expire    = (TIMEOUT_CYCLES != 0) && (w_timer_inc == TO_LIMIT);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and next values of the grant-side registers.
  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_timer_nxt       = r_timer;
    w_grant_nxt       = r_grant;
    w_busy_nxt        = r_busy;
    w_active_nxt      = r_active_id;
    w_output_last_nxt = '0;
    w_timeout_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt  = BUSY;
          w_grant_nxt  = w_pick_onehot[NUM_REQ-1:0];
          w_active_nxt = w_pick;
          w_busy_nxt   = 1'b1;
          w_ptr_nxt    = (w_pick == AID_W'(NUM_REQ - 1)) ? '0 : w_pick + AID_W'(1);
          w_timer_nxt  = '0;
        end
      end
      BUSY: begin
        w_timer_nxt = w_timer_inc;
        // Normal completion wins over a simultaneous watchdog expiry.
        if (bus.i_output_last) begin
          w_state_nxt       = RELEASE;
          w_output_last_nxt = w_active_onehot[NUM_REQ-1:0];
          w_grant_nxt       = '0;
          w_busy_nxt        = 1'b0;
        end else if (w_expire) begin
          w_state_nxt       = RELEASE;
          w_output_last_nxt = w_active_onehot[NUM_REQ-1:0];
          w_timeout_nxt     = 1'b1;
          w_grant_nxt       = '0;
          w_busy_nxt        = 1'b0;
        end
      end
      RELEASE: begin
        // One idle cycle lets the released buffer drop its stale request.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Grant-side registers: pointer, timer, grant, id and the release pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr         <= '0;
      r_timer       <= '0;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_active_id   <= '0;
      r_output_last <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_ptr         <= w_ptr_nxt;
      r_timer       <= w_timer_nxt;
      r_grant       <= w_grant_nxt;
      r_busy        <= w_busy_nxt;
      r_active_id   <= w_active_nxt;
      r_output_last <= w_output_last_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  // Data path: one register stage from the granted lane to the core.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_enb  <= 1'b0;
      r_data <= '0;
    end else begin
      r_enb <= (r_state == BUSY) && w_lane_enb;
      if (r_state == BUSY) r_data <= w_lane_data;
    end
  end

  assign bus.o_grant       = r_grant;
  assign bus.o_enb         = r_enb;
  assign bus.o_data        = r_data;
  assign bus.o_output_last = r_output_last;
  assign bus.o_busy        = r_busy;
  assign bus.o_active_id   = r_active_id;
  assign bus.o_timeout     = r_timeout;
  assign bus.o_dbg_state   = r_state;

endmodule

// File: doc/task_frame_arbiter.md
# task_frame_arbiter

Round-robin scheduler that shares one task processing core between NUM_REQ frame-input buffers. Each buffer reports a complete buffered frame. The arbiter grants exactly one buffer at a time and forwards that buffer's read stream to the core. It routes the core's end-of-output pulse back to the granted buffer, which then reloads. A watchdog releases the core if the end-of-output pulse never arrives.

## Interface
- NUM_REQ, 4: number of requesting buffers, range 2..16.
- DATA_WIDTH, 8: width of forwarded data word.
- TIMEOUT_CYCLES, 4096: maximum cycles from grant to i_output_last; 0 disables the watchdog.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  NUM_REQ  level; bit k high = buffer k holds a frame ready to send.
- i_enb  in  NUM_REQ  per-buffer data-valid strobe.
- i_data  in  NUM_REQ*DATA_WIDTH  per-buffer data; buffer k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_output_last  in  1  core pulse marking the last output word of the current frame.
- o_grant  out  NUM_REQ  one-hot grant; this is the read enable of the selected buffer.
- o_enb  out  1  registered valid to the core.
- o_data  out  DATA_WIDTH  registered data to the core.
- o_output_last  out  NUM_REQ  one-cycle pulse to the granted buffer.
- o_busy  out  1  high while a grant is held.
- o_active_id  out  $clog2(NUM_REQ)  index of the current or last grantee.
- o_timeout  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation
- States: IDLE, BUSY, RELEASE; the state type lives in the shared package.
- IDLE
  - If any i_req bit is set, pick the first set bit searching upward from ptr with wrap.
  - Next edge: o_grant = onehot(pick), o_active_id = pick, o_busy = 1, ptr = (pick+1) mod NUM_REQ, timer cleared, state goes to BUSY.
- BUSY
  - Forward the granted buffer's i_enb and i_data to o_enb and o_data. Strobes from non-granted buffers are ignored.
  - i_output_last high: o_output_last[active_id] pulses on the next edge, o_grant and o_busy drop, state goes to RELEASE.
  - Timer reaches TIMEOUT_CYCLES (nonzero) with no i_output_last: o_timeout pulses and o_output_last[active_id] pulses, so the buffer reloads. o_grant drops and state goes to RELEASE.
  - i_output_last and timer expiry in the same cycle: treated as normal completion; o_timeout stays 0.
- RELEASE
  - Always lasts exactly one cycle, with no grant, then goes to IDLE.
  - This gap absorbs the one-cycle latency of the buffer's empty-flag and request update, so a stale i_req is not re-granted.
- i_output_last in IDLE or RELEASE: ignored, no output pulse.
- i_req dropping during BUSY: no effect; the grant is held until completion or timeout.
- Timer is $clog2(TIMEOUT_CYCLES+1) bits, increments every BUSY cycle, and saturates.

## Timing
- Reset values:
  - o_grant = 0, o_enb = 0, o_data = 0, o_output_last = 0, o_busy = 0, o_active_id = 0, o_timeout = 0.
  - ptr = 0, timer = 0, state = IDLE.
- Reset asserted mid-BUSY: all of the above take effect at that edge; no o_output_last pulse is emitted.
- Request-to-grant latency: 1 cycle, from i_req sampled in IDLE to o_grant high.
- Data latency: i_enb/i_data to o_enb/o_data is 1 register stage. o_enb is 0 in any cycle not preceded by a BUSY cycle.
- i_output_last to o_output_last: 1 cycle.
- Minimum turnaround from completion to next grant: 2 cycles (RELEASE, then IDLE evaluation).
- Back-to-back frames of one buffer with NUM_REQ requesters all active: re-granted after the other NUM_REQ-1 have been served.

## Structure
- Package task_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RELEASE};
  - the function onehot(idx, width);
  - localparam ID_W = $clog2(NUM_REQ) as a helper expression.
- Sub-module task_rr_picker: combinational rotate-priority encoder. Inputs are req and ptr; outputs are valid and idx.
- Top holds the FSM, ptr, timer, data mux and output registers.

## Test plan
- Single requester, NUM_REQ=4: i_req=4'b0010, buffer 1 streams 243 words, then i_output_last.
  - Required: o_grant=4'b0010 one cycle after i_req; 243 o_enb words in order.
  - Required: o_output_last=4'b0010 one cycle after i_output_last; regrant no sooner than 2 cycles later.
- All four requesting continuously: grant order 0,1,2,3,0. A strobe on non-granted i_enb[2] during grant 0 produces no o_enb.
- Watchdog, TIMEOUT_CYCLES=16, no i_output_last: o_timeout and o_output_last[active] pulse 16 cycles after the grant, then the next requester is granted.
- i_output_last coinciding with timer=TIMEOUT_CYCLES: o_output_last pulses, o_timeout stays 0.
- i_rst asserted mid-BUSY on requester 2:
  - All outputs 0 next cycle, no o_output_last pulse.
  - With requesters 1 and 2 both pending afterwards, the first grant goes to 1 because ptr was reset to 0.
